// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with byte/halfword/word access
// Answers CPU requests after WAIT_CYCLES wait states; storage survives reset.
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ack,
    output logic        Busy,
    output logic        AddrErr
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int AW = IW + 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout_q, dout_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          in_idle;
    logic          acc_wr;
    logic [1:0]    acc_size;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [IW-1:0] acc_idx;
    logic [4:0]    lane_sh;
    logic          acc_err;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [31:0]   rd_data;
    logic [31:0]   byte_mask;
    logic [31:0]   merged;
    logic          do_access;
    logic          mem_we;

    // With zero wait states the access happens on the sampling edge, so it
    // must use the live inputs; otherwise the latched copies govern.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        acc_wr    = in_idle ? Wr      : wr_q;
        acc_size  = in_idle ? Size    : size_q;
        acc_addr  = in_idle ? Address : addr_q;
        acc_wdata = in_idle ? Datain  : wdata_q;
        acc_idx   = acc_addr[AW-1:2];
        lane_sh   = {acc_addr[1:0], 3'b000};

        acc_err = (acc_addr[31:AW] != '0);
        case (acc_size)
            2'b00:   if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
            2'b01:   ;
            2'b10:   if (acc_addr[0]) acc_err = 1'b1;
            default: acc_err = 1'b1;
        endcase

        cur_word = mem_q[acc_idx];
        shifted  = cur_word >> lane_sh;
        case (acc_size)
            2'b00:   begin rd_data = cur_word;                   byte_mask = 32'hFFFF_FFFF;          end
            2'b01:   begin rd_data = {24'b0, shifted[7:0]};      byte_mask = 32'h0000_00FF << lane_sh; end
            2'b10:   begin rd_data = {16'b0, shifted[15:0]};     byte_mask = 32'h0000_FFFF << lane_sh; end
            default: begin rd_data = 32'b0;                      byte_mask = 32'b0;                  end
        endcase
        merged = (cur_word & ~byte_mask) | ((acc_wdata << lane_sh) & byte_mask);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        ack_d     = 1'b0;
        busy_d    = 1'b0;
        do_access = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    size_d  = Size;
                    addr_d  = Address;
                    wdata_d = Datain;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        cnt_d     = 4'd0;
                        ack_d     = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                // <= 1 rather than == 1 so a corrupted zero count cannot wedge the FSM
                if (cnt_q <= 4'd1) begin
                    do_access = 1'b1;
                    cnt_d     = 4'd0;
                    ack_d     = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_access) begin
            dout_d = (acc_err || acc_wr) ? 32'b0 : rd_data;
        end
        err_d  = do_access & acc_err;
        mem_we = do_access & ~acc_err & acc_wr & Reset;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            dout_q  <= 32'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage deliberately has no reset so contents survive a Reset pulse.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= merged;
        end
    end

    assign Dataout = dout_q;
    assign Ack     = ack_q;
    assign Busy    = busy_q;
    assign AddrErr = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
// Byte-level memory model predicts each response; a negedge monitor pops and compares.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, din;
    logic [31:0] dout;
    logic        ack, busy, err;

    logic        req0, wr0;
    logic [1:0]  size0;
    logic [31:0] addr0, din0;
    logic [31:0] dout0;
    logic        ack0, busy0, err0;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(64)) dut (
        .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Size(size),
        .Address(addr), .Datain(din), .Dataout(dout), .Ack(ack),
        .Busy(busy), .AddrErr(err)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(64)) dut0 (
        .Clk(clk), .Reset(rst_n), .Req(req0), .Wr(wr0), .Size(size0),
        .Address(addr0), .Datain(din0), .Dataout(dout0), .Ack(ack0),
        .Busy(busy0), .AddrErr(err0)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model [256];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_dout = 32'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_txn(input logic w, input logic [1:0] sz,
                                      input logic [31:0] a, input logic [31:0] d,
                                      output exp_t e);
        int  n;
        logic bad;
        n   = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 1 : 2;
        bad = (a >= 32'd256) || (sz == 2'b11) ||
              (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b10 && a[0]);
        e.err    = bad;
        e.data   = 32'b0;
        e.edge_n = 0;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                if (w) model[8'(a + 32'(i))] = d[8*i +: 8];
                else   e.data[8*i +: 8] = model[8'(a + 32'(i))];
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            last_dout = 32'b0;
        end else if (ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dataout", dout, e.data);
                chk("addrerr", 32'(err), 32'(e.err));
                chk("ack_latency", 32'(cyc - e.edge_n + 1), 32'd3);
            end
            last_dout = dout;
        end else begin
            chk("err_without_ack", 32'(err), 32'd0);
            chk("dout_hold", dout, last_dout);
        end
    end

    task automatic do_txn(input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   budget;
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; addr = a; din = d;
        model_txn(w, sz, a, d, e);
        e.edge_n = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("busy_in_wait", 32'(busy), 32'd1);
        // Inputs wiggle after sampling; the latched values must govern.
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; din = $urandom;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("ack_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req = 0; wr = 0; size = 0; addr = 0; din = 0;
        req0 = 0; wr0 = 0; size0 = 0; addr0 = 0; din0 = 0;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst0_busy", 32'(busy0), 32'd0);
        #2 rst_n = 1'b1;

        do_txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
        do_txn(1'b1, 2'b01, 32'h11, 32'h000000A5);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
        do_txn(1'b0, 2'b01, 32'h13, 32'h0);
        do_txn(1'b0, 2'b10, 32'h12, 32'h0);

        do_txn(1'b0, 2'b10, 32'h11, 32'h0);
        do_txn(1'b0, 2'b00, 32'h02, 32'h0);
        do_txn(1'b0, 2'b00, 32'h100, 32'h0);
        do_txn(1'b0, 2'b11, 32'h10, 32'h0);
        do_txn(1'b1, 2'b00, 32'h100, 32'h11111111);
        do_txn(1'b1, 2'b10, 32'h13, 32'h2222);
        do_txn(1'b1, 2'b11, 32'h10, 32'h33333333);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);

        // Aborted write: reset lands in the first wait cycle.
        do_txn(1'b1, 2'b00, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; din = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_dout", dout, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_txn(1'b0, 2'b00, 32'h20, 32'h0);

        do_txn(1'b1, 2'b00, 32'h34, 32'h0BADF00D);
        do_txn(1'b1, 2'b00, 32'h30, 32'h11223344);
        do_txn(1'b0, 2'b00, 32'h30, 32'h0);
        do_txn(1'b0, 2'b00, 32'h34, 32'h0);

        for (int i = 0; i < 16; i++) do_txn(1'b1, 2'b00, 32'(i * 4), $urandom);
        for (int i = 0; i < 30; i++)
            do_txn(1'($urandom), 2'($urandom), 32'($urandom_range(0, 63)), $urandom);

        // Zero-wait instance: prime one word, then hold Req for six edges.
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; size0 = 2'b00; addr0 = 32'h10; din0 = 32'h55AA1234;
        @(posedge clk);
        @(negedge clk);
        chk("w0_ack", 32'(ack0), 32'd1);
        chk("w0_dout", dout0, 32'd0);
        chk("w0_err", 32'(err0), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        chk("w0_idle_ack", 32'(ack0), 32'd0);
        req0 = 1'b1; wr0 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("b2b_ack", 32'(ack0), 32'(k < 6 && k % 2 == 0));
            chk("b2b_busy", 32'(busy0), 32'(k < 6 && k % 2 == 0));
            chk("b2b_dout", dout0, 32'h55AA1234);
            chk("b2b_err", 32'(err0), 32'd0);
            if (k == 5) req0 = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
